iir_biquad_cascade_n: RTL and testbench
=======================================

Name: iir_biquad_cascade_n

Overview:
- Parametrised successor to the fixed two-section IIR topologies: a cascade of NUM_STAGES Direct-Form-II-Transposed biquads with one shared arithmetic datapath, time-multiplexed across the sections by an FSM.
- Provides a valid/ready sample handshake, run-time coefficient loading, per-stage saturation and a sticky overflow flag.
- Sits between the sample source (ADC/decimator) and downstream DSP.

Parameters:
- DATA_WIDTH, 16, signed sample width of x_in, y_out and the inter-stage values.
- COEFF_WIDTH, 18, signed coefficient width.
- FRAC_BITS, 14, coefficient fractional bits (Q(COEFF_WIDTH-FRAC_BITS).FRAC_BITS).
- NUM_STAGES, 4, number of biquad sections, 1..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- x_in  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  x_in valid.
- in_ready  out  1  block can accept a sample.
- y_out  out  DATA_WIDTH  signed filtered sample.
- out_valid  out  1  y_out valid.
- out_ready  in  1  consumer accepts y_out.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(5*NUM_STAGES)  coefficient index = stage*5 + k, where k = 0:b0, 1:b1, 2:b2, 3:a1, 4:a2.
- coef_wdata  in  COEFF_WIDTH  signed coefficient value.
- coef_err  out  1  one-cycle pulse when a write is rejected.
- clear_state  in  1  zero all delay states (IDLE only).
- sat_flag  out  1  sticky; set when any stage output saturates.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - All s1/s2 states cleared to 0.
  - Every stage loaded with b0 = 1<<FRAC_BITS and b1 = b2 = a1 = a2 = 0, i.e. passthrough.
  - y_out=0, out_valid=0, coef_err=0, sat_flag=0. in_ready=1 from the first cycle after reset.
  - Reset has priority over every other input and aborts any computation in progress; the partial sample is discarded.
- Arithmetic per stage k, input u, all products full precision:
  - acc = b0*u + s1[k].
  - v = sat(acc >>> FRAC_BITS), arithmetic shift (floor), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - s1[k] <= b1*u - a1*v + s2[k].
  - s2[k] <= b2*u - a2*v.
  - States are held unshifted, width DATA_WIDTH+COEFF_WIDTH+3, and wrap on overflow.
  - v of stage k is u of stage k+1; y_out is v of the last stage.
  - sat_flag is set whenever any v clips. It is cleared only by rst.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, x_in is latched, stage counter := 0, next state COMPUTE.
  - COMPUTE: in_ready=0. One stage evaluated per cycle, with that stage's states updated on the same edge. When the counter reaches NUM_STAGES-1, next state DONE, with y_out registered and out_valid=1.
  - DONE: out_valid=1 and y_out held stable until out_ready=1. On that edge out_valid<=0 and the FSM returns to IDLE.
- Latency and throughput:
  - out_valid rises exactly NUM_STAGES cycles after the accepting edge.
  - Minimum input period is NUM_STAGES+2 cycles. A new sample is never accepted in the same cycle as an output handoff.
- Coefficient writes:
  - Accepted only in IDLE when in_valid=0. The new value is used from the next accepted sample.
  - A write in COMPUTE or DONE, a write while in_valid=1 in IDLE, or a write with coef_addr >= 5*NUM_STAGES is ignored, and coef_err pulses on the next cycle.
- clear_state:
  - In IDLE, clear_state zeroes all s1/s2 on that edge and has priority over a simultaneous in_valid, which is not accepted that cycle.
  - Ignored outside IDLE.
- Coefficients are range-limited by COEFF_WIDTH; the block applies no normalisation.

Test Plan:
- Passthrough after reset: feed x = 1000, -2000, 32767 -> y_out = 1000, -2000, 32767. Each out_valid arrives NUM_STAGES cycles after acceptance. sat_flag=0.
- FIR check: NUM_STAGES=1, b0=b1=8192, other coefficients 0. Impulse 1000 then zeros -> y = 500, 500, 0, 0.
- Recursion and saturation: NUM_STAGES=1, b0=16384, a1=-16384. Step input 10000 -> y = 10000, 20000, 30000, 32767, 32767. sat_flag rises on the 4th output and stays high.
- Cascade: 4 stages, each b0=8192, others 0. x = 16000 -> y = 1000; x = -16000 -> y = -1000.
- Handshake and protocol: hold out_ready=0 for 5 cycles -> y_out stable, in_ready=0. A coef_we during COMPUTE -> coef_err pulses, coefficient unchanged. Address 5*NUM_STAGES in IDLE -> coef_err.
- Reset mid-COMPUTE: rst asserted on stage 1 of 4 -> next cycle in IDLE, out_valid=0, y_out=0, coefficients back to passthrough. The next sample 1234 -> y_out = 1234.

Source files
------------

// File: rtl/iir_biquad_cascade_n_if.sv
// Sample handshake, coefficient port and status bundle for iir_biquad_cascade_n.
// The filter takes the slave modport; the sample source / controller takes master.
interface iir_biquad_cascade_n_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 18,
  parameter int NUM_STAGES  = 4
);
  localparam int ADDR_W = $clog2(5 * NUM_STAGES);

  logic signed [DATA_WIDTH-1:0]  x_in;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  y_out;
  logic                          out_valid;
  logic                          out_ready;
  logic                          coef_we;
  logic [ADDR_W-1:0]             coef_addr;
  logic signed [COEFF_WIDTH-1:0] coef_wdata;
  logic                          coef_err;
  logic                          clear_state;
  logic                          sat_flag;

  modport slave (
    input  x_in, in_valid, out_ready, coef_we, coef_addr, coef_wdata, clear_state,
    output in_ready, y_out, out_valid, coef_err, sat_flag
  );

  modport master (
    output x_in, in_valid, out_ready, coef_we, coef_addr, coef_wdata, clear_state,
    input  in_ready, y_out, out_valid, coef_err, sat_flag
  );
endinterface

// File: rtl/iir_biquad_cascade_n.sv
// Cascade of NUM_STAGES DF-II-transposed biquads sharing one multiply/accumulate
// datapath; an FSM walks the sections one per cycle for each accepted sample.
module iir_biquad_cascade_n #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 18,
  parameter int FRAC_BITS   = 14,
  parameter int NUM_STAGES  = 4
) (
  input logic                    clk,
  input logic                    rst,
  iir_biquad_cascade_n_if.slave  bus
);

  localparam int NUM_COEF = 5 * NUM_STAGES;
  localparam int ADDR_W   = $clog2(NUM_COEF);
  localparam int STATE_W  = DATA_WIDTH + COEFF_WIDTH + 3;
  localparam int ACC_W    = STATE_W + 1;
  localparam int STG_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic signed [COEFF_WIDTH-1:0] COEF_ONE = COEFF_WIDTH'(1) << FRAC_BITS;
  localparam logic signed [DATA_WIDTH-1:0]  V_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0]  V_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t state, state_next;

  // Coefficients are laid out exactly as addressed: stage*5 + {b0,b1,b2,a1,a2}.
  logic signed [COEFF_WIDTH-1:0] coef [NUM_COEF];
  logic signed [STATE_W-1:0]     s1   [NUM_STAGES];
  logic signed [STATE_W-1:0]     s2   [NUM_STAGES];

  logic signed [DATA_WIDTH-1:0]  u_reg;
  logic [STG_W-1:0]              stg;
  logic                          last_stage;
  logic                          accept;
  logic                          coef_ok;

  assign last_stage   = (stg == STG_W'(NUM_STAGES - 1));
  assign accept       = (state == IDLE) && !bus.clear_state && bus.in_valid;
  assign coef_ok      = bus.coef_we && (state == IDLE) && !bus.in_valid &&
                        (32'(bus.coef_addr) < NUM_COEF);
  assign bus.in_ready = (state == IDLE);

  // ---------------------------------------------------------------------------
  // Shared section datapath, evaluated for the section selected by stg.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]            base;
  logic signed [ACC_W-1:0]      u_x, v_x;
  logic signed [ACC_W-1:0]      b0_x, b1_x, b2_x, a1_x, a2_x;
  logic signed [ACC_W-1:0]      acc, shifted, s1_acc, s2_acc;
  logic                         clip_hi, clip_lo;
  logic signed [DATA_WIDTH-1:0] v;
  logic signed [STATE_W-1:0]    s1_next, s2_next;

  // NOTE: every always_comb output is assigned on every path (here
  // unconditionally); a missing assignment on some path infers a latch.
  always_comb begin
    base    = ADDR_W'(stg) * ADDR_W'(5);
    b0_x    = ACC_W'(coef[base]);
    b1_x    = ACC_W'(coef[base + ADDR_W'(1)]);
    b2_x    = ACC_W'(coef[base + ADDR_W'(2)]);
    a1_x    = ACC_W'(coef[base + ADDR_W'(3)]);
    a2_x    = ACC_W'(coef[base + ADDR_W'(4)]);
    u_x     = ACC_W'(u_reg);

    // One extra bit over the state width keeps b0*u + s1 exact.
    acc     = b0_x * u_x + ACC_W'(s1[stg]);
    shifted = acc >>> FRAC_BITS;
    clip_hi = !shifted[ACC_W-1] && (|shifted[ACC_W-2:DATA_WIDTH-1]);
    clip_lo =  shifted[ACC_W-1] && !(&shifted[ACC_W-2:DATA_WIDTH-1]);
    v       = clip_hi ? V_MAX : (clip_lo ? V_MIN : shifted[DATA_WIDTH-1:0]);
    v_x     = ACC_W'(v);

    // State updates are allowed to wrap: only the low STATE_W bits are kept.
    s2_acc  = b2_x * u_x - a2_x * v_x;
    s1_acc  = b1_x * u_x - a1_x * v_x + ACC_W'(s2[stg]);
    s1_next = s1_acc[STATE_W-1:0];
    s2_next = s2_acc[STATE_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)        state_next = COMPUTE;
      COMPUTE: if (last_stage)    state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers, coefficient store and status
  // ---------------------------------------------------------------------------
  // NOTE: the coefficient and state arrays are reset on purpose: reset must
  // leave a zero-state passthrough filter, so these cannot map to a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        coef[i] <= (i % 5 == 0) ? COEF_ONE : '0;
      end
      for (int k = 0; k < NUM_STAGES; k++) begin
        s1[k] <= '0;
        s2[k] <= '0;
      end
      u_reg         <= '0;
      stg           <= '0;
      bus.y_out     <= '0;
      bus.out_valid <= 1'b0;
      bus.coef_err  <= 1'b0;
      bus.sat_flag  <= 1'b0;
    end else begin
      bus.coef_err <= bus.coef_we && !coef_ok;
      if (coef_ok) coef[bus.coef_addr] <= bus.coef_wdata;

      unique case (state)
        IDLE: begin
          if (bus.clear_state) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
              s1[k] <= '0;
              s2[k] <= '0;
            end
          end else if (bus.in_valid) begin
            u_reg <= bus.x_in;
            stg   <= '0;
          end
        end
        COMPUTE: begin
          s1[stg] <= s1_next;
          s2[stg] <= s2_next;
          u_reg   <= v;
          if (clip_hi || clip_lo) bus.sat_flag <= 1'b1;
          if (last_stage) begin
            bus.y_out     <= v;
            bus.out_valid <= 1'b1;
          end else begin
            stg <= stg + STG_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) bus.out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade_n.sv
// Scoreboard bench for iir_biquad_cascade_n: the driver queues hand-computed
// outputs, an independent monitor pops and compares them at each handoff.
module tb_iir_biquad_cascade_n;

  localparam int DW = 16;
  localparam int CW = 18;
  localparam int FB = 14;
  localparam int NS = 4;
  localparam int AW = $clog2(5 * NS);
  localparam int ONE  = 1 << FB;
  localparam int HALF = 1 << (FB - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  iir_biquad_cascade_n_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_STAGES(NS)) bus ();

  iir_biquad_cascade_n #(
    .DATA_WIDTH (DW),
    .COEFF_WIDTH(CW),
    .FRAC_BITS  (FB),
    .NUM_STAGES (NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // All driver tasks start and end at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val, input logic exp_err);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(addr);
    bus.coef_wdata = CW'(val);
    tick();
    bus.coef_we = 1'b0;
    check($sformatf("coef_err_addr%0d", addr), bus.coef_err, exp_err);
  endtask

  task automatic set_stage(input int s, input int b0, input int b1, input int b2,
                           input int a1, input int a2);
    write_coef(5 * s + 0, b0, 1'b0);
    write_coef(5 * s + 1, b1, 1'b0);
    write_coef(5 * s + 2, b2, 1'b0);
    write_coef(5 * s + 3, a1, 1'b0);
    write_coef(5 * s + 4, a2, 1'b0);
  endtask

  task automatic clear_states();
    bus.clear_state = 1'b1;
    tick();
    bus.clear_state = 1'b0;
  endtask

  task automatic send_raw(input int x);
    int w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_before_send", bus.in_ready, 1);
    bus.x_in     = DW'(x);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // c counts clock edges since the accepting edge.
  task automatic wait_out(input int start);
    int c = start;
    while (!bus.out_valid && c < 50) begin
      tick();
      c++;
    end
    check("latency", c, NS);
  endtask

  task automatic send(input int x, input int y_exp, input logic sat_exp);
    exp_q.push_back(y_exp);
    send_raw(x);
    wait_out(0);
    check("sat_flag", bus.sat_flag, sat_exp);
    tick();
  endtask

  // Monitor: compare at every handoff, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got y_out=%0d, expected no output", bus.y_out);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("y_out", bus.y_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.x_in        = '0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_wdata  = '0;
    bus.clear_state = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y_out",     bus.y_out,     0);
    check("rst_sat_flag",  bus.sat_flag,  0);
    check("rst_coef_err",  bus.coef_err,  0);

    // Passthrough after reset
    send(1000, 1000, 1'b0);
    send(-2000, -2000, 1'b0);
    send(32767, 32767, 1'b0);

    // FIR on section 0 (0.5 + 0.5 z^-1), others passthrough
    set_stage(0, HALF, HALF, 0, 0, 0);
    clear_states();
    send(1000, 500, 1'b0);
    send(0, 500, 1'b0);
    send(0, 0, 1'b0);
    send(0, 0, 1'b0);

    // Integrator on section 0: y = x + y[-1], clipping from the 4th output
    set_stage(0, ONE, 0, 0, -ONE, 0);
    clear_states();
    send(10000, 10000, 1'b0);
    send(10000, 20000, 1'b0);
    send(10000, 30000, 1'b0);
    send(10000, 32767, 1'b1);
    send(10000, 32767, 1'b1);

    // Four halving sections
    for (int s = 0; s < NS; s++) set_stage(s, HALF, 0, 0, 0, 0);
    clear_states();
    send(16000, 1000, 1'b1);
    send(-16000, -1000, 1'b1);

    // Back-pressure plus a rejected write during COMPUTE
    bus.out_ready = 1'b0;
    exp_q.push_back(500);
    send_raw(8000);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(0);
    bus.coef_wdata = CW'(ONE);
    tick();
    bus.coef_we = 1'b0;
    check("coef_err_compute", bus.coef_err, 1);
    wait_out(1);
    for (int i = 0; i < 5; i++) begin
      check("stall_y_out",     bus.y_out,     500);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready",  bus.in_ready,  0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("handoff_out_valid", bus.out_valid, 0);
    check("handoff_in_ready",  bus.in_ready,  1);
    send(16000, 1000, 1'b1);

    // Out-of-range address is rejected with a single-cycle pulse
    write_coef(5 * NS, ONE, 1'b1);
    tick();
    check("coef_err_pulse_end", bus.coef_err, 0);

    // Reset while section 1 is being evaluated
    send_raw(5000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready",  bus.in_ready,  1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_y_out",     bus.y_out,     0);
    check("midrst_sat_flag",  bus.sat_flag,  0);
    send(1234, 1234, 1'b0);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
